pdm_mic_capture: RTL and testbench

Records audio from the on-board PDM microphone into the 256 × 11-bit wavetable BRAM that the synth's PWM path plays back. It performs the same job as the playback path in the opposite direction. The block generates the microphone clock and decimates the 1-bit PDM stream into 11-bit unsigned samples with a boxcar (ones-count) filter. On a start pulse it writes one full table (addresses 0..255) through the BRAM write port. It sits beside the playback logic in `top` and drives BRAM port B; port A remains the read side for PWM.

---
 rtl/mic_pkg.sv | 28 ++
 rtl/pdm_clkgen.sv | 43 ++++
 rtl/pdm_mic_capture.sv | 149 ++++++++++++++
 tb/tb_pdm_mic_capture.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_pkg.sv
// Shared widths, defaults and state type for the PDM microphone capture path.
package mic_pkg;

  localparam int SAMPLE_W    = 11;
  localparam int ADDR_W      = 8;
  localparam int TABLE_DEPTH = 256;

  localparam int DEFAULT_CLK_DIV = 50;
  localparam int DEFAULT_DECIM   = 64;
  localparam int DEFAULT_SETTLE  = 4;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    CAPTURE,
    DONE
  } cap_state_t;

  // Maps a ones-count (0..decim) onto the full sample range; a full window saturates.
  function automatic logic [SAMPLE_W-1:0] scale_count(input logic [31:0] count,
                                                      input logic [31:0] decim);
    logic [31:0] scaled;
    scaled = count * (32'd2048 / decim);
    if (scaled > 32'd2047) return '1;
    return scaled[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/pdm_clkgen.sv
// Free-running microphone clock divider, M_DATA synchronizer and bit strobe.
module pdm_clkgen
  import mic_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic CLK100MHZ,
  input  logic rst,
  input  logic M_DATA,
  output logic M_CLK,
  output logic bit_strobe,
  output logic bit_val
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       m_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      div_cnt <= '0;
      M_CLK   <= 1'b0;
      m_sync  <= '0;
    end else begin
      m_sync <= {m_sync[0], M_DATA};
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        M_CLK   <= ~M_CLK;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Strobe marks the cycle whose closing edge drives M_CLK from 1 to 0.
  assign bit_strobe = M_CLK && (div_cnt == DIV_LAST);
  assign bit_val    = m_sync[1];

endmodule

// File: rtl/pdm_mic_capture.sv
// Decimates the PDM microphone stream with a boxcar ones-count and writes one
// full 256-entry wavetable through the BRAM write port per start pulse.
module pdm_mic_capture
  import mic_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int DECIM   = DEFAULT_DECIM,
  parameter int SETTLE  = DEFAULT_SETTLE
) (
  input  logic                CLK100MHZ,
  input  logic                rst,
  input  logic                start,
  input  logic                M_DATA,
  output logic                M_CLK,
  output logic                M_LR_SEL,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                busy,
  output logic                done
);

  localparam int WIN_W = $clog2(DECIM);
  localparam int CNT_W = WIN_W + 1;
  localparam int FL_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(DECIM - 1);
  localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'(SETTLE - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(TABLE_DEPTH - 1);

  logic                bit_strobe;
  logic                bit_val;
  logic [WIN_W-1:0]    win_cnt;
  logic [CNT_W-1:0]    ones_acc;
  logic                win_done;
  logic [CNT_W-1:0]    win_count;
  logic [SAMPLE_W-1:0] win_sample;

  cap_state_t          state, state_nxt;
  logic [FL_W-1:0]     flush_cnt, flush_cnt_nxt;
  logic                flush_skip, flush_skip_nxt;
  logic [ADDR_W-1:0]   index, index_nxt;
  logic                wr_en_nxt;
  logic [ADDR_W-1:0]   wr_addr_nxt;
  logic [SAMPLE_W-1:0] wr_data_nxt;
  logic                done_nxt;

  pdm_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .CLK100MHZ  (CLK100MHZ),
    .rst        (rst),
    .M_DATA     (M_DATA),
    .M_CLK      (M_CLK),
    .bit_strobe (bit_strobe),
    .bit_val    (bit_val)
  );

  assign M_LR_SEL   = 1'b0;
  assign win_done   = bit_strobe && (win_cnt == WIN_LAST);
  assign win_count  = ones_acc + CNT_W'(bit_val);
  assign win_sample = scale_count(32'(win_count), 32'(DECIM));
  assign busy       = (state != IDLE);

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      win_cnt  <= '0;
      ones_acc <= '0;
    end else if (bit_strobe) begin
      if (win_done) begin
        win_cnt  <= '0;
        ones_acc <= '0;
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        ones_acc <= win_count;
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state      <= IDLE;
      flush_cnt  <= '0;
      flush_skip <= 1'b0;
      index      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_cnt  <= flush_cnt_nxt;
      flush_skip <= flush_skip_nxt;
      index      <= index_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      done       <= done_nxt;
    end
  end

  // NOTE: every always_comb output is defaulted first so no path leaves a
  // value unassigned and infers a latch.
  always_comb begin
    state_nxt      = state;
    flush_cnt_nxt  = flush_cnt;
    flush_skip_nxt = flush_skip;
    index_nxt      = index;
    wr_en_nxt      = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;
    done_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt      = FLUSH;
          flush_cnt_nxt  = '0;
          // The window already in progress is discarded unless it ends right now.
          flush_skip_nxt = !win_done;
        end
      end
      FLUSH: begin
        if (win_done) begin
          if (flush_skip) begin
            flush_skip_nxt = 1'b0;
          end else if (flush_cnt == FLUSH_LAST) begin
            state_nxt = CAPTURE;
            index_nxt = '0;
          end else begin
            flush_cnt_nxt = flush_cnt + 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (win_done) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = index;
          wr_data_nxt = win_sample;
          index_nxt   = index + 1'b1;
          if (index == LAST_ADDR) state_nxt = DONE;
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Self-checking bench: a PDM microphone model feeds bit patterns on M_CLK and a
// window-sum reference predicts every table write.
module tb_pdm_mic_capture;

  localparam int CLK_DIV = 2;
  localparam int DECIM   = 8;
  localparam int SETTLE  = 4;
  localparam int DEPTH   = 256;
  localparam int WIN     = DECIM * 2 * CLK_DIV;
  localparam int STEP    = 2048 / DECIM;
  localparam int BUDGET  = (SETTLE + DEPTH + 3) * WIN;

  logic        CLK100MHZ = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        M_DATA;
  logic        M_CLK;
  logic        M_LR_SEL;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [10:0] wr_data;
  logic        busy;
  logic        done;

  pdm_mic_capture #(.CLK_DIV(CLK_DIV), .DECIM(DECIM), .SETTLE(SETTLE)) dut (
    .CLK100MHZ (CLK100MHZ),
    .rst       (rst),
    .start     (start),
    .M_DATA    (M_DATA),
    .M_CLK     (M_CLK),
    .M_LR_SEL  (M_LR_SEL),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          exp_data;
    int          cyc;
    int          cmp_cyc;
  } wr_rec_t;

  // Monitor-owned state.
  wr_rec_t wr_log[$];
  int      win_bits[$];
  int      cyc = 0;
  int      done_count = 0;
  int      done_cyc = 0;
  logic    done_busy = 1'b0;
  int      last_wr_cyc = 0;
  int      toggles = 0;
  int      gap_bad = 0;
  int      last_tog = 0;
  int      last_val = 0;
  int      last_cmp_cyc = -1;
  int      bit_idx = 0;
  logic    prev_mclk = 1'b0;

  // Driver-owned state.
  int mode = 0;
  int checks = 0;
  int errors = 0;

  function automatic logic next_bit(input int m, input int idx);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (idx % 2) == 0;
      3:       return (idx % DECIM) < 3;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Microphone model and reference: the bit present at each M_CLK falling edge is
  // taken; every DECIM taken bits since reset form one window.
  initial begin
    logic rst_seen;
    wr_rec_t rec;
    int ones;
    M_DATA = 1'b0;
    forever begin
      @(posedge CLK100MHZ);
      rst_seen = rst;
      #1;
      cyc++;
      if (rst_seen) begin
        win_bits.delete();
        prev_mclk = 1'b0;
        last_tog  = cyc;
      end else begin
        if (M_CLK !== prev_mclk) begin
          if (cyc - last_tog != CLK_DIV) gap_bad++;
          toggles++;
          last_tog = cyc;
        end
        if (prev_mclk === 1'b1 && M_CLK === 1'b0) begin
          win_bits.push_back(int'(M_DATA));
          if (win_bits.size() == DECIM) begin
            ones = 0;
            foreach (win_bits[k]) ones += win_bits[k];
            last_val     = (ones * STEP > 2047) ? 2047 : ones * STEP;
            last_cmp_cyc = cyc;
            win_bits.delete();
          end
          bit_idx++;
          M_DATA = next_bit(mode, bit_idx);
        end
        prev_mclk = M_CLK;
      end
      if (wr_en === 1'b1) begin
        rec.addr     = {24'b0, wr_addr};
        rec.data     = {21'b0, wr_data};
        rec.exp_data = last_val;
        rec.cyc      = cyc;
        rec.cmp_cyc  = last_cmp_cyc;
        wr_log.push_back(rec);
        last_wr_cyc = cyc;
      end
      if (done === 1'b1) begin
        done_count++;
        done_cyc  = cyc;
        done_busy = busy;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK100MHZ);
    start = 1'b1;
    @(negedge CLK100MHZ);
    start = 1'b0;
  endtask

  // One full capture; exp_const < 0 means only the reference model is used.
  task automatic run_capture(input int m, input bit dbl_start, input int exp_const, input string name);
    int base, dbase, start_cyc, n, nw, lat;
    wr_rec_t r;
    mode  = m;
    base  = wr_log.size();
    dbase = done_count;
    pulse_start();
    start_cyc = cyc;
    check({name, "_busy_rise"}, busy, 1);
    if (dbl_start) begin
      repeat (2 * WIN) @(negedge CLK100MHZ);
      pulse_start();
    end
    n = 0;
    while (done_count == dbase && n < BUDGET) begin
      @(negedge CLK100MHZ);
      n++;
    end
    repeat (4) @(negedge CLK100MHZ);
    check({name, "_done_count"}, done_count - dbase, 1);
    nw = wr_log.size() - base;
    check({name, "_write_count"}, nw, DEPTH);
    if (nw > DEPTH) nw = DEPTH;
    for (int i = 0; i < nw; i++) begin
      r = wr_log[base + i];
      check($sformatf("%s_addr[%0d]", name, i), r.addr, i);
      check($sformatf("%s_data[%0d]", name, i), r.data, r.exp_data);
      if (exp_const >= 0) check($sformatf("%s_const[%0d]", name, i), r.data, exp_const);
      check($sformatf("%s_wr_after_window[%0d]", name, i), r.cyc, r.cmp_cyc);
      if (i > 0) check($sformatf("%s_spacing[%0d]", name, i), r.cyc - wr_log[base + i - 1].cyc, WIN);
    end
    if (nw > 0) begin
      lat = wr_log[base].cyc - start_cyc;
      checks++;
      assert (lat >= SETTLE * WIN && lat <= (SETTLE + 2) * WIN + 1)
      else begin
        errors++;
        $error("FAIL %s_first_write_latency observed=%0d expected=%0d..%0d",
               name, lat, SETTLE * WIN, (SETTLE + 2) * WIN + 1);
      end
      check({name, "_addr_hold"}, wr_addr, 255);
      check({name, "_data_hold"}, wr_data, wr_log[base + nw - 1].data);
    end
    check({name, "_done_after_last_write"}, done_cyc - last_wr_cyc, 1);
    check({name, "_busy_with_done"}, done_busy, 0);
    check({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int t0, w0, d0, base, dbase, n;

    // Reset state while rst is held.
    repeat (3) @(negedge CLK100MHZ);
    check("rst_M_CLK", M_CLK, 0);
    check("rst_M_LR_SEL", M_LR_SEL, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // Idle: mic clock runs, nothing is written.
    t0 = toggles;
    w0 = wr_log.size();
    d0 = done_count;
    repeat (1000) @(negedge CLK100MHZ);
    check("idle_toggles", toggles - t0, 1000 / CLK_DIV);
    check("idle_writes", wr_log.size() - w0, 0);
    check("idle_done", done_count - d0, 0);
    check("idle_busy", busy, 0);
    check("idle_M_LR_SEL", M_LR_SEL, 0);

    // start coincident with rst: reset wins.
    @(negedge CLK100MHZ);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge CLK100MHZ);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", busy, 0);
    repeat (5) @(negedge CLK100MHZ);
    check("rst_start_busy_later", busy, 0);

    run_capture(1, 1'b1, 2047, "ones");
    run_capture(0, 1'b0, 0, "zeros");
    run_capture(2, 1'b0, 1024, "alt");
    run_capture(3, 1'b0, 3 * STEP, "three");
    run_capture(4, 1'b0, -1, "rand");

    // Reset right after the write to address 100.
    mode  = 4;
    base  = wr_log.size();
    dbase = done_count;
    pulse_start();
    n = 0;
    while (wr_log.size() - base < 101 && n < BUDGET) begin
      @(negedge CLK100MHZ);
      n++;
    end
    check("mid_reached_101_writes", wr_log.size() - base, 101);
    if (wr_log.size() - base >= 101) check("mid_addr100", wr_log[base + 100].addr, 100);
    rst = 1'b1;
    @(negedge CLK100MHZ);
    rst = 1'b0;
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    repeat (4 * WIN) @(negedge CLK100MHZ);
    check("mid_no_more_writes", wr_log.size() - base, 101);
    check("mid_no_done", done_count - dbase, 0);
    check("mid_busy_later", busy, 0);
    check("mid_wr_en_later", wr_en, 0);

    run_capture(4, 1'b0, -1, "restart");

    check("mclk_gap_errors", gap_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
